// File: rtl/bfly_stream.sv
// bfly_stream: streaming radix-2 DIT butterfly.
// Three-stage pipeline (multiply, combine/round, add/scale/saturate) computing
// P = A + W*B and M = A - W*B. It has a valid/ready handshake and carries a tag
// alongside each sample. The whole pipe advances as one unit. Empty slots
// (bubbles) stay in the pipe and are not squeezed out.
module bfly_stream #(
  parameter int DATA_W  = 22,
  parameter int TW_W    = 12,
  parameter int TW_FRAC = 11,
  parameter int TAG_W   = 6
) (
  input  logic                clk_50,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*DATA_W-1:0] in_a,
  input  logic [2*DATA_W-1:0] in_b,
  input  logic [2*TW_W-1:0]   in_w,
  input  logic                in_scale,
  input  logic                in_inv,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DATA_W-1:0] out_p,
  output logic [2*DATA_W-1:0] out_m,
  output logic [TAG_W-1:0]    out_tag,
  output logic                out_sat,
  output logic                ovf_sticky,
  input  logic                ovf_clr
);

  localparam int PW = DATA_W + TW_W;   // full product width
  localparam int SW = PW + 1;          // product sum width
  localparam int XW = DATA_W + 2;      // internal butterfly width

  localparam logic signed [SW-1:0] RND   = SW'(1) << (TW_FRAC - 1);
  localparam logic signed [XW-1:0] MAX_X = XW'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [XW-1:0] MIN_X = ~MAX_X;

  logic advance;

  logic signed [PW-1:0] b_re_x, b_im_x, w_re_x, w_im_x;

  logic                  s1_valid;
  logic signed [PW-1:0]  s1_rr, s1_ii, s1_ri, s1_ir;
  logic [2*DATA_W-1:0]   s1_a;
  logic                  s1_scale, s1_inv;
  logic [TAG_W-1:0]      s1_tag;

  logic signed [SW-1:0]  sum_re, sum_im;
  logic signed [XW-1:0]  t_re_next, t_im_next;

  logic                  s2_valid;
  logic signed [XW-1:0]  s2_t_re, s2_t_im;
  logic [2*DATA_W-1:0]   s2_a;
  logic                  s2_scale;
  logic [TAG_W-1:0]      s2_tag;

  logic signed [XW-1:0]  a_re_x, a_im_x;
  logic signed [XW-1:0]  p_re_x, p_im_x, m_re_x, m_im_x;
  logic [DATA_W:0]       sat_pr, sat_pi, sat_mr, sat_mi;

  // The pipe moves whenever the output register is empty or being drained.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  assign b_re_x = PW'($signed(in_b[2*DATA_W-1:DATA_W]));
  assign b_im_x = PW'($signed(in_b[DATA_W-1:0]));
  assign w_re_x = PW'($signed(in_w[2*TW_W-1:TW_W]));
  assign w_im_x = PW'($signed(in_w[TW_W-1:0]));

  // Clamp one component to the output range. The top bit flags a clamp.
  function automatic logic [DATA_W:0] saturate(input logic signed [XW-1:0] x);
    logic [DATA_W:0] r;
    if (x > MAX_X)
      r = {1'b1, MAX_X[DATA_W-1:0]};
    else if (x < MIN_X)
      r = {1'b1, MIN_X[DATA_W-1:0]};
    else
      r = {1'b0, x[DATA_W-1:0]};
    return r;
  endfunction

  // Stage 1: register the four partial products plus A and the sideband bits.
  always_ff @(posedge clk_50) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_rr    <= '0;
      s1_ii    <= '0;
      s1_ri    <= '0;
      s1_ir    <= '0;
      s1_a     <= '0;
      s1_scale <= 1'b0;
      s1_inv   <= 1'b0;
      s1_tag   <= '0;
    end else if (advance) begin
      s1_valid <= in_valid;
      s1_rr    <= b_re_x * w_re_x;
      s1_ii    <= b_im_x * w_im_x;
      s1_ri    <= b_re_x * w_im_x;
      s1_ir    <= b_im_x * w_re_x;
      s1_a     <= in_a;
      s1_scale <= in_scale;
      s1_inv   <= in_inv;
      s1_tag   <= in_tag;
    end
  end

  // Combine products into T = W*B (or conj(W)*B), then round half-up to data scale.
  always_comb begin
    sum_re = '0;
    sum_im = '0;
    if (s1_inv) begin
      sum_re = SW'(s1_rr) + SW'(s1_ii);
      sum_im = SW'(s1_ir) - SW'(s1_ri);
    end else begin
      sum_re = SW'(s1_rr) - SW'(s1_ii);
      sum_im = SW'(s1_ri) + SW'(s1_ir);
    end
    t_re_next = XW'((sum_re + RND) >>> TW_FRAC);
    t_im_next = XW'((sum_im + RND) >>> TW_FRAC);
  end

  // Stage 2: register the rounded twiddle product alongside A.
  always_ff @(posedge clk_50) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_t_re  <= '0;
      s2_t_im  <= '0;
      s2_a     <= '0;
      s2_scale <= 1'b0;
      s2_tag   <= '0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      s2_t_re  <= t_re_next;
      s2_t_im  <= t_im_next;
      s2_a     <= s1_a;
      s2_scale <= s1_scale;
      s2_tag   <= s1_tag;
    end
  end

  // Butterfly add/subtract, optional halving with rounding, then clamp.
  always_comb begin
    a_re_x = XW'($signed(s2_a[2*DATA_W-1:DATA_W]));
    a_im_x = XW'($signed(s2_a[DATA_W-1:0]));
    p_re_x = a_re_x + s2_t_re;
    p_im_x = a_im_x + s2_t_im;
    m_re_x = a_re_x - s2_t_re;
    m_im_x = a_im_x - s2_t_im;
    if (s2_scale) begin
      p_re_x = (p_re_x + XW'(1)) >>> 1;
      p_im_x = (p_im_x + XW'(1)) >>> 1;
      m_re_x = (m_re_x + XW'(1)) >>> 1;
      m_im_x = (m_im_x + XW'(1)) >>> 1;
    end
    sat_pr = saturate(p_re_x);
    sat_pi = saturate(p_im_x);
    sat_mr = saturate(m_re_x);
    sat_mi = saturate(m_im_x);
  end

  // Stage 3: output register. It holds its value while downstream stalls.
  always_ff @(posedge clk_50) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_p     <= '0;
      out_m     <= '0;
      out_tag   <= '0;
      out_sat   <= 1'b0;
    end else if (advance) begin
      out_valid <= s2_valid;
      out_p     <= {sat_pr[DATA_W-1:0], sat_pi[DATA_W-1:0]};
      out_m     <= {sat_mr[DATA_W-1:0], sat_mi[DATA_W-1:0]};
      out_tag   <= s2_tag;
      out_sat   <= s2_valid & (sat_pr[DATA_W] | sat_pi[DATA_W] |
                               sat_mr[DATA_W] | sat_mi[DATA_W]);
    end
  end

  // Sticky overflow: set when a saturated result leaves; a set beats a clear.
  always_ff @(posedge clk_50) begin
    if (rst)
      ovf_sticky <= 1'b0;
    else if (out_valid && out_ready && out_sat)
      ovf_sticky <= 1'b1;
    else if (ovf_clr)
      ovf_sticky <= 1'b0;
  end

endmodule

// File: doc/bfly_stream.md
Name: bfly_stream

Overview:
- Radix-2 decimation-in-time butterfly with a streaming valid/ready handshake, a 3-stage pipeline and rounding.
- Computes P = A + W*B and M = A - W*B on complex operands every cycle when not stalled.
- Optional per-sample 1/2 scaling, per-sample inverse (conjugate-twiddle) mode and saturation with overflow reporting.
- Successor to the muxed MAC butterfly: twiddle/data selection moves upstream to the FFT stage controller, which feeds one butterfly per cycle plus an opaque tag.

Parameters:
- DATA_W, 22, bits per real/imag data component (signed two's complement).
- TW_W, 12, bits per real/imag twiddle component (signed).
- TW_FRAC, 11, fractional bits of twiddle (Q1.11 by default).
- TAG_W, 6, width of sideband tag carried alongside each sample.

Ports:
- clk_50  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block accepts input this cycle.
- in_a  in  2*DATA_W  {re,im} of A; re in upper half.
- in_b  in  2*DATA_W  {re,im} of B.
- in_w  in  2*TW_W  {re,im} twiddle.
- in_scale  in  1  1 = divide both results by 2.
- in_inv  in  1  1 = use conj(W) (inverse FFT).
- in_tag  in  TAG_W  sideband, returned unchanged with result.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_p  out  2*DATA_W  {re,im} of A + W*B.
- out_m  out  2*DATA_W  {re,im} of A - W*B.
- out_tag  out  TAG_W  tag of this result.
- out_sat  out  1  any of the four output components saturated, qualified by out_valid.
- ovf_sticky  out  1  set on any saturated transferred result; cleared by ovf_clr or rst.
- ovf_clr  in  1  clears ovf_sticky.

Behaviour:
- Reset: all stage valid bits, out_valid, out_sat and ovf_sticky = 0; out_p, out_m, out_tag = 0. Reset mid-operation discards all in-flight samples on the next edge.
- Pipeline control: advance = !out_valid || out_ready. in_ready = advance (combinational from out_ready). All 3 stages load only when advance = 1. Bubbles are not collapsed.
- Transfers: input accepted when in_valid && in_ready; output consumed when out_valid && out_ready.
- Latency: exactly 3 advancing cycles from accept to out_valid. Throughput 1/cycle with out_ready held high.
- Stall: while out_valid && !out_ready, out_p, out_m, out_tag and out_sat hold stable and no input is accepted.
- S1 (multiply): register four signed products br*wr, bi*wi, br*wi, bi*wr, each DATA_W+TW_W bits. Register A, scale, inv and tag alongside.
- S2 (combine): register T = W*B.
  - Normal: Tre = br*wr - bi*wi, Tim = br*wi + bi*wr.
  - inv = 1: Tre = br*wr + bi*wi, Tim = bi*wr - br*wi.
  - Each sum is rounded half-up: add 2^(TW_FRAC-1), then arithmetic shift right by TW_FRAC. Keep DATA_W+2 bits.
- S3 (butterfly): P = A + T, M = A - T, computed at DATA_W+2 bits.
  - If scale = 1: each component becomes (x+1)>>>1, arithmetic.
  - Saturate each component to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - out_sat = OR of the four saturation events.
- ovf_sticky: set on the cycle a result with out_sat = 1 transfers. If ovf_clr and a set event occur in the same cycle, set wins.
- W = -2^(TW_W-1) + 0j (i.e. -1.0) is legal and handled exactly. No +1.0 exists; +1.0 is approximated by 2^TW_FRAC - 1.

Test Plan:
- Basic forward: a=(100,50), b=(40,-20), w=(0,-2048), scale=0, inv=0 -> after 3 cycles out_p=(80,10), out_m=(120,90), out_sat=0.
- Same sample with scale=1 -> out_p=(40,5), out_m=(60,45).
- Same sample with inv=1, scale=0 -> out_p=(120,90), out_m=(80,10).
- Saturation: a=(2097151,0), b=(2000,0), w=(-2048,0) -> out_p=(2095151,0), out_m=(2097151,0), out_sat=1, ovf_sticky=1 after transfer; pulse ovf_clr -> ovf_sticky=0.
- Backpressure: stream 8 tagged samples (tags 0..7), drop out_ready for 4 cycles mid-stream -> in_ready=0 during stall, outputs held; all 8 results emerge in tag order, none lost or duplicated.
- Reset mid-stream: assert rst with 3 samples in flight -> out_valid=0 next cycle; no stale result appears after rst deasserts.
